// File: rtl/arc4_seq_if.sv
// arc4_seq_if: start handshake, sub-engine handshakes and shared S-memory port of the ARC4 sequencer.
interface arc4_seq_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int KEY_W = 24
);
    logic en, rdy;
    logic [KEY_W-1:0] key, key_q;
    logic init_en, ksa_en, prga_en;
    logic init_rdy, ksa_rdy, prga_rdy;
    logic [ADDR_W-1:0] init_addr, ksa_addr, prga_addr, s_addr;
    logic [DATA_W-1:0] init_wrdata, ksa_wrdata, prga_wrdata, s_wrdata;
    logic init_wren, ksa_wren, prga_wren, s_wren;
    logic [1:0] phase;
    logic err;
    modport master (
        output en, key, init_rdy, ksa_rdy, prga_rdy,
        output init_addr, ksa_addr, prga_addr, init_wrdata, ksa_wrdata, prga_wrdata,
        output init_wren, ksa_wren, prga_wren,
        input rdy, key_q, init_en, ksa_en, prga_en, s_addr, s_wrdata, s_wren, phase, err
    );
    modport slave (
        input en, key, init_rdy, ksa_rdy, prga_rdy,
        input init_addr, ksa_addr, prga_addr, init_wrdata, ksa_wrdata, prga_wrdata,
        input init_wren, ksa_wren, prga_wren,
        output rdy, key_q, init_en, ksa_en, prga_en, s_addr, s_wrdata, s_wren, phase, err
    );
endinterface

// File: rtl/arc4_seq.sv
// arc4_seq: runs ARC4 init, ksa and prga engines in order and muxes the shared S-memory port.
// Defining ARC4_SEQ_WDOG_EN adds a per-phase watchdog that traps in ERR until rst.
module arc4_seq #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int KEY_W = 24,
    parameter int TIMEOUT_CYCLES = 16383
) (
    input logic clk,
    input logic rst,
    arc4_seq_if.slave bus
);
`ifdef ARC4_SEQ_WDOG_EN
    typedef enum logic [2:0] {IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT} state_t;
`endif
    state_t state;
    logic seen_busy, go, cur_rdy, done;
    logic [1:0] grp;
    always_comb begin
        grp = (state == INIT_GO || state == INIT_WAIT) ? 2'd1 :
              (state == KSA_GO || state == KSA_WAIT) ? 2'd2 :
              (state == PRGA_GO || state == PRGA_WAIT) ? 2'd3 : 2'd0;
        go = state == INIT_GO || state == KSA_GO || state == PRGA_GO;
        cur_rdy = grp == 2'd1 ? bus.init_rdy : grp == 2'd2 ? bus.ksa_rdy : grp == 2'd3 && bus.prga_rdy;
        done = grp != 2'd0 && !go && cur_rdy && seen_busy;
    end
    assign bus.phase = grp;
    assign bus.init_en = state == INIT_GO && bus.init_rdy;
    assign bus.ksa_en = state == KSA_GO && bus.ksa_rdy;
    assign bus.prga_en = state == PRGA_GO && bus.prga_rdy;
    // GO states already select their engine so writes issued alongside en reach memory
    assign bus.s_addr = grp == 2'd1 ? bus.init_addr : grp == 2'd2 ? bus.ksa_addr :
                        grp == 2'd3 ? bus.prga_addr : ADDR_W'(0);
    assign bus.s_wrdata = grp == 2'd1 ? bus.init_wrdata : grp == 2'd2 ? bus.ksa_wrdata :
                          grp == 2'd3 ? bus.prga_wrdata : DATA_W'(0);
    assign bus.s_wren = grp == 2'd1 ? bus.init_wren : grp == 2'd2 ? bus.ksa_wren :
                        grp == 2'd3 && bus.prga_wren;
`ifdef ARC4_SEQ_WDOG_EN
    logic [14:0] wd_cnt;
    logic timeout;
    assign timeout = grp != 2'd0 && wd_cnt + 15'd1 == 15'(TIMEOUT_CYCLES);
    assign bus.err = state == ERR;
    always_ff @(posedge clk)
        wd_cnt <= (rst || state == IDLE || done) ? 15'd0 : wd_cnt + 15'd1;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign bus.err = 1'b0;
`endif
    // seen_busy guards against a stale rdy still high just after the engine's en
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bus.rdy <= 1'b1;
            bus.key_q <= KEY_W'(0);
            seen_busy <= 1'b0;
`ifdef ARC4_SEQ_WDOG_EN
        end else if (timeout) begin
            state <= ERR;
            bus.rdy <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (bus.en) begin
                state <= INIT_GO;
                bus.rdy <= 1'b0;
                bus.key_q <= bus.key;
            end
        end else if (go) begin
            if (cur_rdy) begin
                state <= state_t'(state + 3'd1);
                seen_busy <= 1'b0;
            end
        end else if (grp != 2'd0) begin
            seen_busy <= seen_busy || !cur_rdy;
            if (done) begin
                state <= state == PRGA_WAIT ? IDLE : state_t'(state + 3'd1);
                bus.rdy <= state == PRGA_WAIT;
            end
        end
    end
endmodule

// File: tb/tb_arc4_seq.sv
// tb_arc4_seq: randomized engine timings and mux traffic checked against a phase-timeline model.
module tb_arc4_seq;
`ifdef ARC4_SEQ_WDOG_EN
    localparam int TO = 20;
`else
    localparam int TO = 16383;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int nchk = 0;
    int nerr = 0;
    int stale[3] = '{0, 0, 0};
    int run[3] = '{10, 10, 10};
    int sc[3] = '{0, 0, 0};
    int rc[3] = '{0, 0, 0};
    logic erdy[3] = '{1'b1, 1'b1, 1'b1};
    bit stuck[3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] a[3], d[3];
    logic w[3];
    bit fixmux = 1'b0;

    arc4_seq_if #(.ADDR_W(8), .DATA_W(8), .KEY_W(24)) bus();
    arc4_seq #(.ADDR_W(8), .DATA_W(8), .KEY_W(24), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.init_rdy = erdy[0];
    assign bus.ksa_rdy = erdy[1];
    assign bus.prga_rdy = erdy[2];

    // Engine model: rdy stays high for stale[i] cycles after en, then low for run[i] cycles
    always @(posedge clk) begin
        logic [2:0] ens;
        ens = {bus.prga_en, bus.ksa_en, bus.init_en};
        for (int i = 0; i < 3; i++) begin
            if (ens[i]) begin
                sc[i] = stale[i];
                rc[i] = run[i];
            end
            if (sc[i] > 0) begin
                sc[i]--;
                erdy[i] <= !stuck[i];
            end else if (rc[i] > 0) begin
                rc[i]--;
                erdy[i] <= 1'b0;
            end else
                erdy[i] <= !stuck[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_mux();
        for (int i = 0; i < 3; i++) begin
            a[i] = 8'($urandom);
            d[i] = 8'($urandom);
            w[i] = 1'($urandom);
        end
        if (fixmux) begin
            a[1] = 8'h5A;
            d[1] = 8'hC3;
            w[1] = 1'b1;
            w[0] = 1'b1;
        end
        bus.init_addr = a[0]; bus.init_wrdata = d[0]; bus.init_wren = w[0];
        bus.ksa_addr = a[1]; bus.ksa_wrdata = d[1]; bus.ksa_wren = w[1];
        bus.prga_addr = a[2]; bus.prga_wrdata = d[2]; bus.prga_wren = w[2];
    endtask

    function automatic logic [16:0] exp_mux(input int p);
        return p == 0 ? 17'd0 : {a[p-1], d[p-1], w[p-1]};
    endfunction

    function automatic logic [6:0] ctl();
        return {bus.rdy, bus.err, bus.phase, bus.init_en, bus.ksa_en, bus.prga_en};
    endfunction

    // Each phase lasts stale+run+2 cycles: GO, stale window, busy window, final rdy cycle
    task automatic run_txn(input logic [23:0] key_in);
        int l[3], gs[3], total, p;
        logic [2:0] enb;
        for (int i = 0; i < 3; i++) l[i] = stale[i] + run[i] + 2;
        gs[0] = 1;
        gs[1] = gs[0] + l[0];
        gs[2] = gs[1] + l[1];
        total = gs[2] + l[2];
        bus.en = 1'b1;
        bus.key = key_in;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            bus.en = 1'b0;
            if (k < total - 1 && $urandom_range(0, 7) == 0) begin
                bus.en = 1'b1;
                bus.key = 24'hFFFFFF;
            end
            drive_mux();
            #1;
            p = k == total ? 0 : k >= gs[2] ? 3 : k >= gs[1] ? 2 : 1;
            enb = 3'b000;
            if (p != 0 && k == gs[p-1]) enb[3-p] = 1'b1;
            chk("ctl", ctl(), {k == total, 1'b0, 2'(p), enb});
            chk("mux", {bus.s_addr, bus.s_wrdata, bus.s_wren}, exp_mux(p));
            chk("key_q", bus.key_q, key_in);
        end
    endtask

    task automatic reset_mid();
        stale = '{0, 0, 0};
        run = '{10, 10, 10};
        bus.en = 1'b1;
        bus.key = 24'h123456;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            bus.en = 1'b0;
            drive_mux();
        end
        #1;
        chk("mid_phase", bus.phase, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst", ctl(), 7'b1000000);
        chk("mid_wren", bus.s_wren, 0);
        chk("mid_key", bus.key_q, 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive_mux();
            #1;
            chk("mid_idle", ctl(), 7'b1000000);
            chk("mid_mux", {bus.s_addr, bus.s_wrdata, bus.s_wren}, 0);
        end
    endtask

`ifdef ARC4_SEQ_WDOG_EN
    task automatic wdog_txn();
        int gs2;
        stale = '{0, 0, 0};
        run = '{4, 4, 4};
        stuck[2] = 1'b1;
        gs2 = 13;
        bus.en = 1'b1;
        bus.key = 24'h0000AB;
        for (int k = 1; k <= gs2 + 25; k++) begin
            @(negedge clk);
            bus.en = 1'b0;
            drive_mux();
            #1;
            chk("wd_err", bus.err, k >= gs2 + 20);
            if (k >= gs2 + 20) chk("wd_trap", ctl(), 7'b0100000);
            if (k >= gs2 + 20) chk("wd_wren", bus.s_wren, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stuck[2] = 1'b0;
        #1;
        chk("wd_rst", ctl(), 7'b1000000);
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL timeout: simulation bound expired");
        $fatal(1);
    end

    initial begin
        bus.en = 1'b0;
        bus.key = 24'h0;
        drive_mux();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ctl", ctl(), 7'b1000000);
        chk("rst_mux", {bus.s_addr, bus.s_wrdata, bus.s_wren}, 0);
        chk("rst_key", bus.key_q, 0);
        rst = 1'b0;
        run_txn(24'h000318);
        stale = '{0, 3, 0};
        run_txn(24'($urandom));
        stale = '{0, 0, 0};
        fixmux = 1'b1;
        run_txn(24'($urandom));
        fixmux = 1'b0;
        reset_mid();
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 3; i++) begin
                stale[i] = $urandom_range(0, 3);
                run[i] = $urandom_range(1, 12);
            end
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_txn(24'($urandom));
        end
`ifdef ARC4_SEQ_WDOG_EN
        wdog_txn();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/arc4_seq.md
Name: arc4_seq

Overview:
- Top-level sequencer for the ARC4 decryption core.
- On one start request it runs three sub-engines in order: S-array init, then key schedule (ksa), then keystream/decrypt (prga).
- Each sub-engine is driven over the team's en/rdy handshake.
- Owns the single S-memory port and multiplexes it to whichever sub-engine is active; s_rddata goes directly from memory to all engines and does not pass through this block.

Parameters:
- ADDR_W, 8, S-memory address width
- DATA_W, 8, S-memory data width
- KEY_W, 24, key width
- TIMEOUT_CYCLES, 16383, per-phase watchdog limit; used only when ARC4_SEQ_WDOG_EN is defined

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  block idle and able to accept en
- key  in  KEY_W  key, sampled on accepted en
- key_q  out  KEY_W  latched key, fed to ksa and prga
- init_en, ksa_en, prga_en  out  1 each  one-cycle start pulse per sub-engine
- init_rdy, ksa_rdy, prga_rdy  in  1 each  sub-engine idle/finished
- init_addr, ksa_addr, prga_addr  in  ADDR_W each  sub-engine S address
- init_wrdata, ksa_wrdata, prga_wrdata  in  DATA_W each  sub-engine S write data
- init_wren, ksa_wren, prga_wren  in  1 each  sub-engine S write enable
- s_addr  out  ADDR_W  muxed S-memory address
- s_wrdata  out  DATA_W  muxed S-memory write data
- s_wren  out  1  muxed S-memory write enable
- phase  out  2  0 idle, 1 init, 2 ksa, 3 prga
- err  out  1  watchdog fault flag; constant 0 without ARC4_SEQ_WDOG_EN

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, rdy=1, all *_en=0, key_q=0, phase=0, err=0, s_wren=0, s_addr=0, s_wrdata=0.
- Reset mid-operation: returns to IDLE on the next edge. Sub-engines are not told; each sees no further en pulse.
- States: IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT, plus ERR (macro only).
- IDLE:
  - rdy=1.
  - If en=1, latch key into key_q and go to INIT_GO.
  - en while rdy=0 is ignored (no queuing).
- X_GO (X = init/ksa/prga):
  - Waits until X_rdy=1, then asserts X_en for exactly that one cycle and enters X_WAIT.
  - X_en is combinational from state and X_rdy, so it is high only in the GO cycle where X_rdy=1.
- X_WAIT:
  - Flag seen_busy is cleared on GO→WAIT and set on any cycle with X_rdy=0.
  - Exit when X_rdy=1 and seen_busy=1. This prevents a stale rdy, still high in the cycle after en, from ending the phase early.
  - Exits: INIT_WAIT→KSA_GO, KSA_WAIT→PRGA_GO, PRGA_WAIT→IDLE.
- rdy:
  - Registered, 0 from the cycle after an accepted en.
  - Returns to 1 on the edge that leaves PRGA_WAIT.
- Minimum latency:
  - 7 cycles of sequencing overhead on top of sub-engine run times.
  - Back-to-back en is accepted in the first IDLE cycle.
- Memory mux (combinational, selected by registered state):
  - INIT_* → init_* signals.
  - KSA_* → ksa_* signals.
  - PRGA_* → prga_* signals.
  - IDLE/ERR → s_addr=0, s_wrdata=0, s_wren=0.
  - GO states already select their engine, so writes issued in the en cycle pass through.
- phase follows the state group; it is 0 in IDLE and ERR.
- key_q holds its value until the next accepted en. It does not change during a run.
- Widths: ADDR_W/DATA_W paths are pass-through with no arithmetic.

Optional Feature:
- Macro: ARC4_SEQ_WDOG_EN.
- Defined:
  - A 15-bit counter clears on entry to each GO state and increments in GO/WAIT.
  - When it reaches TIMEOUT_CYCLES, go to ERR: err=1, rdy=0, all *_en=0, s_wren=0.
  - ERR is left only by rst.
- Undefined:
  - No counter and no ERR state; err is tied to 0.
  - An engine that never finishes stalls the block indefinitely.

Test Plan:
- Basic run: rst, then en=1 with key=24'h000318. Each engine model drops rdy 1 cycle after en and raises it after 10 cycles. Required: init_en, ksa_en, prga_en each pulse once, in order; phase steps 1→2→3→0; rdy=1 returns 7+30 cycles after en; key_q=24'h000318 throughout.
- Stale rdy: ksa model keeps ksa_rdy=1 for 3 cycles after ksa_en before dropping. Required: still in KSA_WAIT with phase=2, no prga_en until ksa_rdy rises again.
- Mux: in phase 2 drive ksa_addr=8'h5A, ksa_wrdata=8'hC3, ksa_wren=1 and init_wren=1. Required: s_addr=8'h5A, s_wrdata=8'hC3, s_wren=1. In IDLE, all three s_* outputs are 0.
- Ignored en: pulse en during PRGA_WAIT with key=24'hFFFFFF. Required: key_q unchanged, no extra init_en after completion.
- Reset mid-run: assert rst during KSA_WAIT. Required: next cycle rdy=1, phase=0, s_wren=0, no further *_en pulses.
- Watchdog (with ARC4_SEQ_WDOG_EN, TIMEOUT_CYCLES=20): prga_rdy stuck at 0. Required: err=1 20 cycles after PRGA_GO, s_wren=0, err cleared only by rst.
